uart_rx: RTL

//  UART receiver; counterpart of the UART transmitter. Deserialises 8N/8O/8E frames from pin rx
//  (1 start, 8 data LSB-first, optional parity, 1 stop) using the receive oversampling enable from baud_rate_en.

---
 rtl/uart_rx.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronised rx, oversampled mid-bit sampling, 8 data bits LSB-first,
// optional parity, one stop bit, rdy/ack handshake with parity/framing/overrun flags.
module uart_rx #(
   parameter string PARITY = "ODD",
   parameter int    OVS    = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_bd_en,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_rdy,
   input  logic       rx_ack,
   output logic       rx_perr,
   output logic       rx_ferr,
   output logic       rx_ovr
);

   localparam bit HAS_PAR = (PARITY != "NONE");
   localparam bit ODD_PAR = (PARITY == "ODD");
   localparam int TW      = $clog2(OVS);
   localparam logic [TW-1:0] T_MID  = TW'(OVS / 2 - 1);
   localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_t;

   state_t        state_reg, state_next;
   logic [1:0]    sync_reg;
   logic          rxs;
   logic [TW-1:0] tick_reg, tick_next;
   logic [2:0]    bit_reg, bit_next;
   logic          perr_reg, perr_next;
   logic [7:0]    shift_reg;
   logic [7:0]    cap_en;
   logic          data_sample;
   logic          frame_done;

   assign rxs = sync_reg[1];

   always_ff @(posedge clk) begin
      if (rst) sync_reg <= 2'b11;
      else     sync_reg <= {sync_reg[0], rx};
   end

   // State register: everything in the framing path only moves on a baud tick
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         tick_reg  <= '0;
         bit_reg   <= '0;
         perr_reg  <= 1'b0;
      end else if (rx_bd_en) begin
         state_reg <= state_next;
         tick_reg  <= tick_next;
         bit_reg   <= bit_next;
         perr_reg  <= perr_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      bit_next   = bit_reg;
      perr_next  = perr_reg;
      case (state_reg)
         S_IDLE:
            if (!rxs) state_next = S_START;
         S_START:
            if (tick_reg == T_MID) begin
               if (rxs) begin
                  state_next = S_IDLE;
               end else begin
                  state_next = S_DATA;
                  bit_next   = 3'd0;
                  perr_next  = 1'b0;
               end
            end
         S_DATA:
            if (tick_reg == T_LAST) begin
               bit_next = bit_reg + 3'd1;
               if (bit_reg == 3'd7) state_next = HAS_PAR ? S_PARITY : S_STOP;
            end
         S_PARITY:
            if (tick_reg == T_LAST) begin
               perr_next  = ((^{shift_reg, rxs}) != ODD_PAR);
               state_next = S_STOP;
            end
         S_STOP:
            if (tick_reg == T_LAST) state_next = rxs ? S_IDLE : S_BREAK;
         S_BREAK:
            if (rxs) state_next = S_IDLE;
         default:
            state_next = S_IDLE;
      endcase
      tick_next = (state_next != state_reg || tick_reg == T_LAST) ? '0 : tick_reg + 1'b1;
   end

   always_comb begin
      data_sample = rx_bd_en && (state_reg == S_DATA) && (tick_reg == T_LAST);
      frame_done  = rx_bd_en && (state_reg == S_STOP) && (tick_reg == T_LAST);
   end

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_cap
         assign cap_en[gi] = data_sample && (bit_reg == 3'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_reg <= '0;
      end else begin
         for (int i = 0; i < 8; i++)
            if (cap_en[i]) shift_reg[i] <= rxs;
      end
   end

   // Completion beats ack: a simultaneous ack consumes the old byte, so no overrun
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data <= '0;
         rx_rdy  <= 1'b0;
         rx_perr <= 1'b0;
         rx_ferr <= 1'b0;
         rx_ovr  <= 1'b0;
      end else if (frame_done) begin
         rx_data <= shift_reg;
         rx_perr <= perr_reg;
         rx_ferr <= ~rxs;
         rx_rdy  <= 1'b1;
         rx_ovr  <= rx_rdy & ~rx_ack;
      end else if (rx_ack && rx_rdy) begin
         rx_rdy  <= 1'b0;
         rx_ovr  <= 1'b0;
      end
   end

endmodule
